// File: rtl/spu_wb_pkg.sv
// Shared types and defaults for the SPU writeback pipes.
package spu_wb_pkg;

  localparam int unsigned WB_DEPTH = 7;

  typedef logic [0:2]   wb_lat_t;
  typedef logic [0:6]   wb_addr_t;
  typedef logic [0:127] wb_data_t;

  typedef struct packed {
    logic     valid;
    wb_addr_t addr;
    wb_data_t data;
  } wb_entry_t;

  // A latency is usable only if it lands inside the pipe (1..depth).
  function automatic logic lat_legal(input wb_lat_t lat, input int unsigned depth);
    return (lat != '0) && (32'(lat) <= depth);
  endfunction

endpackage

// File: rtl/wb_lane.sv
// One writeback pipe: DEPTH-stage shift register, final stage drives the write port.
// Optional pending-address compare is built when WB_PENDING_EN is defined.
module wb_lane
  import spu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_flush,
  input  logic      i_valid,
  input  wb_addr_t  i_addr,
  input  wb_data_t  i_data,
  input  wb_lat_t   i_lat,
`ifdef WB_PENDING_EN
  input  wb_addr_t  i_pend_addr,
  output logic      o_pend,
`endif
  output wb_entry_t o_head,
  output logic      o_collide,
  output logic      o_bad_lat
);

  wb_entry_t   r_stage [DEPTH];
  wb_entry_t   w_next  [DEPTH];
  logic        w_insert;
  int unsigned w_slot;

  always_comb begin
    o_bad_lat = i_valid && !i_flush && !lat_legal(i_lat, DEPTH);
    w_insert  = i_valid && !i_flush && lat_legal(i_lat, DEPTH);
    w_slot    = DEPTH - 32'(i_lat);
    o_collide = 1'b0;

    // Flush empties every stage; the entry in the final stage still writes this cycle.
    w_next[0] = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_next[i] = i_flush ? '0 : r_stage[i-1];
    end

    if (w_insert) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i == w_slot) begin
          o_collide = w_next[i].valid;
          w_next[i] = '{valid: 1'b1, addr: i_addr, data: i_data};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i] <= w_next[i];
      end
    end
  end

  assign o_head = r_stage[DEPTH-1];

`ifdef WB_PENDING_EN
  always_comb begin
    o_pend = 1'b0;
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if (r_stage[i].valid && (r_stage[i].addr == i_pend_addr)) begin
        o_pend = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/writeback_pipe.sv
// Even/odd writeback pipes with same-address arbitration (odd wins) and sticky error.
// Define WB_PENDING_EN to add the pend_addr / pend_even / pend_odd lookup ports.
module writeback_pipe
  import spu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         even_valid,
  input  logic         odd_valid,
  input  logic [0:6]   even_rt_addr,
  input  logic [0:6]   odd_rt_addr,
  input  logic [0:127] even_result,
  input  logic [0:127] odd_result,
  input  logic [0:2]   even_lat,
  input  logic [0:2]   odd_lat,
  input  logic         flush,
  output logic [0:6]   rt_addr_even,
  output logic [0:6]   rt_addr_odd,
  output logic [0:127] rt_even,
  output logic [0:127] rt_odd,
  output logic         reg_write_even,
  output logic         reg_write_odd,
`ifdef WB_PENDING_EN
  input  logic [0:6]   pend_addr,
  output logic         pend_even,
  output logic         pend_odd,
`endif
  output logic         wb_err
);

  wb_entry_t w_even_head;
  wb_entry_t w_odd_head;
  logic      w_even_collide;
  logic      w_odd_collide;
  logic      w_even_bad;
  logic      w_odd_bad;
  logic      w_same_addr;
  logic      r_err;

  wb_lane #(.DEPTH(DEPTH)) u_even (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (flush),
    .i_valid    (even_valid),
    .i_addr     (even_rt_addr),
    .i_data     (even_result),
    .i_lat      (even_lat),
`ifdef WB_PENDING_EN
    .i_pend_addr(pend_addr),
    .o_pend     (pend_even),
`endif
    .o_head     (w_even_head),
    .o_collide  (w_even_collide),
    .o_bad_lat  (w_even_bad)
  );

  wb_lane #(.DEPTH(DEPTH)) u_odd (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (flush),
    .i_valid    (odd_valid),
    .i_addr     (odd_rt_addr),
    .i_data     (odd_result),
    .i_lat      (odd_lat),
`ifdef WB_PENDING_EN
    .i_pend_addr(pend_addr),
    .o_pend     (pend_odd),
`endif
    .o_head     (w_odd_head),
    .o_collide  (w_odd_collide),
    .o_bad_lat  (w_odd_bad)
  );

  // Arbitration reads only stage registers, so no issue input reaches the write ports.
  assign w_same_addr = w_even_head.valid && w_odd_head.valid &&
                       (w_even_head.addr == w_odd_head.addr);

  assign reg_write_even = w_even_head.valid && !w_same_addr;
  assign rt_addr_even   = w_even_head.addr;
  assign rt_even        = w_even_head.data;
  assign reg_write_odd  = w_odd_head.valid;
  assign rt_addr_odd    = w_odd_head.addr;
  assign rt_odd         = w_odd_head.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_even_collide || w_odd_collide || w_even_bad || w_odd_bad) begin
      r_err <= 1'b1;
    end
  end

  assign wb_err = r_err;

endmodule

// File: tb/tb_writeback_pipe.sv
// Scoreboard bench for writeback_pipe: absolute-cycle write schedule as reference model.
module tb_writeback_pipe;
  import spu_wb_pkg::*;

  localparam int unsigned D     = WB_DEPTH;
  localparam int          NM    = 1024;
  localparam int          NRAND = 400;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         even_valid = 1'b0, odd_valid = 1'b0;
  logic [0:6]   even_rt_addr = '0, odd_rt_addr = '0;
  logic [0:127] even_result = '0, odd_result = '0;
  logic [0:2]   even_lat = '0, odd_lat = '0;
  logic [0:6]   rt_addr_even, rt_addr_odd;
  logic [0:127] rt_even, rt_odd;
  logic         reg_write_even, reg_write_odd, wb_err;
`ifdef WB_PENDING_EN
  logic [0:6]   pend_addr = '0;
  logic         pend_even, pend_odd;
`endif

  always #5 clk = ~clk;

  writeback_pipe #(.DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .even_valid    (even_valid),
    .odd_valid     (odd_valid),
    .even_rt_addr  (even_rt_addr),
    .odd_rt_addr   (odd_rt_addr),
    .even_result   (even_result),
    .odd_result    (odd_result),
    .even_lat      (even_lat),
    .odd_lat       (odd_lat),
    .flush         (flush),
    .rt_addr_even  (rt_addr_even),
    .rt_addr_odd   (rt_addr_odd),
    .rt_even       (rt_even),
    .rt_odd        (rt_odd),
    .reg_write_even(reg_write_even),
    .reg_write_odd (reg_write_odd),
`ifdef WB_PENDING_EN
    .pend_addr     (pend_addr),
    .pend_even     (pend_even),
    .pend_odd      (pend_odd),
`endif
    .wb_err        (wb_err)
  );

  // Reference model: per pipe, which write (if any) is due in each absolute cycle.
  bit         m_v [2][NM];
  bit [0:6]   m_a [2][NM];
  bit [0:127] m_d [2][NM];
  bit         m_err;
  int         cyc = 0;
  logic [0:6] g_pa = '0;

  typedef struct {
    int         cyc;
    bit         rst;
    bit         err;
    bit         we_e;
    bit [0:6]   a_e;
    bit [0:127] d_e;
    bit         we_o;
    bit [0:6]   a_o;
    bit [0:127] d_o;
`ifdef WB_PENDING_EN
    bit         pe;
    bit         po;
`endif
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void chk(input string nm, input int c, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, exp);
    end
  endfunction

  function automatic void model_issue(input int p, input bit v, input bit [0:6] a,
                                      input bit [0:127] d, input int l);
    int t;
    if (!v) return;
    if (l < 1 || l > int'(D)) begin
      m_err = 1'b1;
      return;
    end
    t = cyc + l;
    if (m_v[p][t]) m_err = 1'b1;
    m_v[p][t] = 1'b1;
    m_a[p][t] = a;
    m_d[p][t] = d;
  endfunction

  task automatic step(input bit rst, input bit fl,
                      input bit ev, input bit [0:6] ea, input bit [0:127] ed, input int el,
                      input bit ov, input bit [0:6] oa, input bit [0:127] od, input int ol);
    exp_t x;
    @(posedge clk);
    #1;
    reset        = rst;
    flush        = fl;
    even_valid   = ev;
    even_rt_addr = ea;
    even_result  = ed;
    even_lat     = 3'(el);
    odd_valid    = ov;
    odd_rt_addr  = oa;
    odd_result   = od;
    odd_lat      = 3'(ol);
`ifdef WB_PENDING_EN
    pend_addr    = g_pa;
`endif
    if (rst) begin
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < NM; k++) m_v[p][k] = 1'b0;
      m_err = 1'b0;
    end
    x.cyc  = cyc;
    x.rst  = rst;
    x.err  = m_err;
    x.we_o = m_v[1][cyc];
    x.a_o  = m_a[1][cyc];
    x.d_o  = m_d[1][cyc];
    x.we_e = m_v[0][cyc] && !(m_v[1][cyc] && (m_a[1][cyc] == m_a[0][cyc]));
    x.a_e  = m_a[0][cyc];
    x.d_e  = m_d[0][cyc];
`ifdef WB_PENDING_EN
    x.pe = 1'b0;
    x.po = 1'b0;
    for (int k = cyc + 1; k <= cyc + int'(D); k++) begin
      if (m_v[0][k] && m_a[0][k] == g_pa) x.pe = 1'b1;
      if (m_v[1][k] && m_a[1][k] == g_pa) x.po = 1'b1;
    end
`endif
    exp_q.push_back(x);
    if (!rst) begin
      if (fl) begin
        for (int k = cyc + 1; k <= cyc + int'(D); k++) begin
          m_v[0][k] = 1'b0;
          m_v[1][k] = 1'b0;
        end
      end else begin
        model_issue(0, ev, ea, ed, el);
        model_issue(1, ov, oa, od, ol);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic rst_cycles(input int n);
    repeat (n) step(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic iss_e(input bit [0:6] a, input bit [0:127] d, input int l);
    step(0, 0, 1, a, d, l, 0, '0, '0, 0);
  endtask

  task automatic iss_o(input bit [0:6] a, input bit [0:127] d, input int l);
    step(0, 0, 0, '0, '0, 0, 1, a, d, l);
  endtask

  function automatic bit [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: one expectation per cycle, compared away from the clock edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("wb_err", x.cyc, 128'(wb_err), 128'(x.err));
        chk("reg_write_even", x.cyc, 128'(reg_write_even), 128'(x.we_e));
        chk("reg_write_odd", x.cyc, 128'(reg_write_odd), 128'(x.we_o));
        if (x.we_e) begin
          chk("rt_addr_even", x.cyc, 128'(rt_addr_even), 128'(x.a_e));
          chk("rt_even", x.cyc, 128'(rt_even), 128'(x.d_e));
        end
        if (x.we_o) begin
          chk("rt_addr_odd", x.cyc, 128'(rt_addr_odd), 128'(x.a_o));
          chk("rt_odd", x.cyc, 128'(rt_odd), 128'(x.d_o));
        end
        if (x.rst) begin
          chk("reset_rt_addr_even", x.cyc, 128'(rt_addr_even), '0);
          chk("reset_rt_even", x.cyc, 128'(rt_even), '0);
          chk("reset_rt_addr_odd", x.cyc, 128'(rt_addr_odd), '0);
          chk("reset_rt_odd", x.cyc, 128'(rt_odd), '0);
        end
`ifdef WB_PENDING_EN
        chk("pend_even", x.cyc, 128'(pend_even), 128'(x.pe));
        chk("pend_odd", x.cyc, 128'(pend_odd), 128'(x.po));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         r_rst, r_fl, r_ev, r_ov;
    int         r_el, r_ol;
    bit [0:127] aa;
    aa = {16{8'hAA}};

    rst_cycles(3);
    idle(2);
    // Even L=2 single write.
    iss_e(7'd5, aa, 2);
    idle(4);
    // Even L=7 then L=1 six cycles later: both target the same cycle.
    iss_e(7'd1, rnd128(), 7);
    idle(5);
    iss_e(7'd2, rnd128(), 1);
    idle(3);
    rst_cycles(1);
    // Same-address simultaneous write: odd wins, no error.
    step(0, 0, 1, 7'd9, rnd128(), 4, 1, 7'd9, rnd128(), 4);
    idle(6);
    // Odd L=6 killed by flush; odd entry due in the flush cycle still writes.
    iss_o(7'd11, rnd128(), 6);
    iss_o(7'd12, rnd128(), 2);
    idle(1);
    step(0, 1, 0, '0, '0, 0, 0, '0, '0, 0);
    idle(5);
    // Issue during flush is dropped.
    step(0, 1, 1, 7'd13, rnd128(), 1, 1, 7'd14, rnd128(), 3);
    idle(4);
    // L=0 drop sets the sticky error.
    iss_e(7'd3, rnd128(), 0);
    idle(3);
    rst_cycles(1);
    // Reset in the middle of an L=5 flight.
    iss_e(7'd3, rnd128(), 5);
    idle(1);
    rst_cycles(1);
    idle(7);
    // Pending lookup for an odd L=3 entry.
    g_pa = 7'd20;
    iss_o(7'd20, rnd128(), 3);
    idle(4);

    for (int n = 0; n < NRAND; n++) begin
      r_rst = ($urandom_range(99) == 0);
      r_fl  = ($urandom_range(24) == 0);
      r_ev  = ($urandom_range(1) == 1);
      r_ov  = ($urandom_range(1) == 1);
      r_el  = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(D, 1));
      r_ol  = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(D, 1));
      g_pa  = 7'($urandom_range(7));
      step(r_rst, r_fl, r_ev, 7'($urandom_range(7)), rnd128(), r_el,
           r_ov, 7'($urandom_range(7)), rnd128(), r_ol);
    end
    idle(int'(D) + 1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc, 128'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_pipe.md
WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter DEPTH, default 7: number of in-flight stages per pipe, equal to the maximum unit latency.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 even_valid, odd_valid  in  1  execute unit is issuing a result this cycle.
REQ-006 even_rt_addr, odd_rt_addr  in  [0:6]  destination register of the issued result.
REQ-007 even_result, odd_result  in  [0:127]  value of the issued result.
REQ-008 even_lat, odd_lat  in  [0:2]  unit latency L; legal range 1..DEPTH.
REQ-009 flush  in  1  kills younger in-flight odd/even results (branch redirect).
REQ-010 rt_addr_even, rt_addr_odd  out  [0:6]  register-file write address.
REQ-011 rt_even, rt_odd  out  [0:127]  register-file write data.
REQ-012 reg_write_even, reg_write_odd  out  1  register-file write enable.
REQ-013 wb_err  out  1  sticky error flag.

Function
REQ-014 A result issued at cycle t with latency L SHALL appear on its pipe's write port with reg_write asserted during cycle t+L only.
REQ-015 Each pipe SHALL be a DEPTH-stage shift register; an issue inserts at stage DEPTH-L, entries advance one stage per cycle, and the final stage drives the write port.
REQ-016 Write-port outputs SHALL be registered, with no combinational path from issue inputs to outputs.
REQ-017 If L=0, the issue SHALL be dropped and wb_err set.
REQ-018 If the insertion slot already holds a valid entry after the shift, the new entry SHALL overwrite it and wb_err SHALL be set.
REQ-019 flush SHALL clear the valid bit of every stage except the final stage, so that a write presenting in the flush cycle completes. An issue in the same cycle as flush SHALL be dropped.
REQ-020 If both pipes would write the same address in the same cycle, reg_write_even SHALL be suppressed, odd SHALL win, and wb_err SHALL NOT be set.
REQ-021 Pipes SHALL otherwise be fully independent, and simultaneous even and odd issues SHALL both be accepted.
REQ-022 wb_err SHALL remain set until reset.

Reset
REQ-023 Reset SHALL clear all stage valid bits and wb_err, and drive reg_write_* = 0, rt_addr_* = 0 and rt_* = 0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight entries; no write SHALL occur in the cycle after reset deasserts.

Configuration
REQ-025 With WB_PENDING_EN defined, the module SHALL add the following ports:
- pend_addr  in  [0:6]
- pend_even  out  1
- pend_odd  out  1
Each pend output SHALL be a combinational indication that a valid in-flight entry of that pipe, excluding its final stage, targets pend_addr.
REQ-026 Without WB_PENDING_EN, those ports and their compare logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package spu_wb_pkg SHALL hold DEPTH, the wb_entry_t struct (valid, addr[0:6], data[0:127]) and the latency type.
REQ-028 Sub-module wb_lane SHALL implement one shift-register pipe, be instantiated twice, and have arbitration and wb_err in the top level.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Even issue: addr 5, data 0xAA..AA, L=2 at cycle 10 -> reg_write_even=1, rt_addr_even=5 at cycle 12 only.
- Even L=7 at cycle 0 and even L=1 at cycle 6, different addresses -> writes at cycles 7 and 7? Illegal for one port, so expect overwrite and wb_err=1; the second result writes at cycle 7.
- Odd L=4 addr 9 and even L=4 addr 9 in the same cycle -> at +4 reg_write_odd=1, reg_write_even=0, wb_err=0.
- Odd L=6 at cycle 0, flush at cycle 3 -> no odd write at cycle 6; an entry due at cycle 3 is still written.
- Issue L=0 -> no write, wb_err=1 until reset; reset at cycle 2 of an L=5 issue -> no write ever.
- With WB_PENDING_EN: issue odd L=3 addr 20 -> pend_odd=1 for pend_addr=20 in cycles +1..+2, and 0 at +3.
